// File: rtl/iir_mc.sv
// Time-multiplexed multi-channel direct-form-I biquad with one shared MAC,
// runtime-loadable coefficients and saturating output.
module iir_mc #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 16,
  parameter int COEF_W   = 8,
  parameter int FRAC     = 0,
  parameter int CHANNELS = 4,
  parameter int B0       = 4,
  parameter int B1       = -4,
  parameter int B2       = 4,
  parameter int A1       = 1,
  parameter int A2       = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ACC_W   = OUT_W + COEF_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [2:0]        coef_sel,
  input  logic [COEF_W-1:0] coef_data
);

  localparam int PROD_W = OUT_W + COEF_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] RES  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Handshake: a transfer happens on a posedge where valid && ready are both
  // high; the sender holds valid and its payload stable until that edge.

  logic [1:0]               state;
  logic [2:0]               tap;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x_cur;
  logic [CH_W-1:0]          ch_cur;
  logic                     ch_ok;

  logic signed [COEF_W-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;

  logic signed [DATA_W-1:0] x1_mem [CHANNELS];
  logic signed [DATA_W-1:0] x2_mem [CHANNELS];
  logic signed [OUT_W-1:0]  y1_mem [CHANNELS];
  logic signed [OUT_W-1:0]  y2_mem [CHANNELS];

  logic signed [DATA_W-1:0] x1_rd, x2_rd;
  logic signed [OUT_W-1:0]  y1_rd, y2_rd;
  logic signed [COEF_W-1:0] coef_op;
  logic signed [OUT_W-1:0]  data_op;
  logic                     sub_op;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  y_res;
  logic                     sat_res;
  logic                     in_range;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign in_range  = ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));

  // Out-of-range channels see an all-zero history.
  always_comb begin
    x1_rd = '0;
    x2_rd = '0;
    y1_rd = '0;
    y2_rd = '0;
    if (ch_ok) begin
      x1_rd = x1_mem[ch_cur];
      x2_rd = x2_mem[ch_cur];
      y1_rd = y1_mem[ch_cur];
      y2_rd = y2_mem[ch_cur];
    end
  end

  always_comb begin
    coef_op = '0;
    data_op = '0;
    sub_op  = 1'b0;
    case (tap)
      3'd0: begin coef_op = c_b0; data_op = OUT_W'(x_cur); end
      3'd1: begin coef_op = c_b1; data_op = OUT_W'(x1_rd); end
      3'd2: begin coef_op = c_b2; data_op = OUT_W'(x2_rd); end
      3'd3: begin coef_op = c_a1; data_op = y1_rd; sub_op = 1'b1; end
      3'd4: begin coef_op = c_a2; data_op = y2_rd; sub_op = 1'b1; end
      default: ;
    endcase
  end

  assign prod     = PROD_W'(coef_op) * PROD_W'(data_op);
  assign acc_next = sub_op ? (acc - ACC_W'(prod)) : (acc + ACC_W'(prod));
  assign shifted  = acc >>> FRAC;

  always_comb begin
    y_res   = shifted[OUT_W-1:0];
    sat_res = 1'b0;
    if (shifted > Y_MAX) begin
      y_res   = Y_MAX[OUT_W-1:0];
      sat_res = 1'b1;
    end else if (shifted < Y_MIN) begin
      y_res   = Y_MIN[OUT_W-1:0];
      sat_res = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tap      <= '0;
      acc      <= '0;
      x_cur    <= '0;
      ch_cur   <= '0;
      ch_ok    <= 1'b0;
      out_data <= '0;
      out_ch   <= '0;
      out_sat  <= 1'b0;
      c_b0     <= COEF_W'(B0);
      c_b1     <= COEF_W'(B1);
      c_b2     <= COEF_W'(B2);
      c_a1     <= COEF_W'(A1);
      c_a2     <= COEF_W'(A2);
      for (int i = 0; i < CHANNELS; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else begin
      // Writes land before the first MAC cycle, so a write on the accept edge
      // already applies to that sample.
      if (coef_we && state == IDLE) begin
        case (coef_sel)
          3'd0: c_b0 <= coef_data;
          3'd1: c_b1 <= coef_data;
          3'd2: c_b2 <= coef_data;
          3'd3: c_a1 <= coef_data;
          3'd4: c_a2 <= coef_data;
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_cur  <= in_data;
            ch_cur <= in_ch;
            ch_ok  <= in_range;
            acc    <= '0;
            tap    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 3'd1;
          if (tap == 3'd4) state <= RES;
        end
        RES: begin
          out_data <= y_res;
          out_ch   <= ch_cur;
          out_sat  <= sat_res;
          if (ch_ok) begin
            x2_mem[ch_cur] <= x1_mem[ch_cur];
            x1_mem[ch_cur] <= x_cur;
            y2_mem[ch_cur] <= y1_mem[ch_cur];
            y1_mem[ch_cur] <= y_res;
          end
          state <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mc.sv
// Directed bench for iir_mc: impulse, channel isolation, saturation,
// backpressure, coefficient-write gating and mid-flight reset.
module tb_iir_mc;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;
  localparam int COEF_W = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  logic              coef_we;
  logic [2:0]        coef_sel;
  logic [COEF_W-1:0] coef_data;

  int checks   = 0;
  int failures = 0;

  // Entry layout: {channel, sat, data}
  logic [CH_W+OUT_W:0] exp_q[$];

  int imp_y[5] = '{4, -8, 12, -12, 12};

  iir_mc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_sel(coef_sel), .coef_data(coef_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_coef(input int sel, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_sel = 3'(sel); coef_data = COEF_W'(val);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Handshake completes on the posedge after the driving negedge; returns at edge+1.
  task automatic push(input int ch, input int data, input int exp_y, input bit exp_sat);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_push", in_ready, 1);
    in_ch = CH_W'(ch); in_data = DATA_W'(data); in_valid = 1'b1;
    exp_q.push_back({CH_W'(ch), exp_sat, OUT_W'(exp_y)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pull(input bit hold, input int exp_lat);
    int lat = 0;
    logic [CH_W+OUT_W:0] e;
    logic [OUT_W-1:0] snap_d;
    logic [CH_W-1:0]  snap_c;
    logic             snap_s;
    bit stable = 1'b1;
    bit busy   = 1'b1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    e = exp_q.pop_front();
    check("out_data", $signed(out_data), $signed(e[OUT_W-1:0]));
    check("out_sat", out_sat, e[OUT_W]);
    check("out_ch", out_ch, e[CH_W+OUT_W:OUT_W+1]);
    if (hold) begin
      snap_d = out_data; snap_c = out_ch; snap_s = out_sat;
      repeat (10) begin
        @(posedge clk); #1;
        if (!(out_valid && out_data == snap_d && out_ch == snap_c && out_sat == snap_s)) stable = 1'b0;
        if (in_ready) busy = 1'b0;
      end
      check("bp_out_stable", stable, 1);
      check("bp_in_ready_low", busy, 1);
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("out_valid_after_xfer", out_valid, 0);
    check("in_ready_after_xfer", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_v;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_sel = '0; coef_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_sat", out_sat, 0);

    // Impulse response with default coefficients
    for (int i = 0; i < 5; i++) begin
      push(0, (i == 0) ? 1 : 0, imp_y[i], 1'b0);
      pull(1'b0, 6);
    end

    // Channel isolation: ch1 zeros interleaved with the ch0 impulse
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(0, (i == 0) ? 1 : 0, imp_y[i], 1'b0);
      pull(1'b0, 6);
      push(1, 0, 0, 1'b0);
      pull(1'b0, 6);
    end

    // Backpressure
    do_reset();
    out_ready = 1'b0;
    push(0, 1, 4, 1'b0);
    pull(1'b1, 6);

    // Coefficient write during MAC is dropped; in IDLE it applies
    do_reset();
    push(0, 1, 4, 1'b0);
    @(negedge clk);
    coef_we = 1'b1; coef_sel = 3'd0; coef_data = '0;
    @(negedge clk);
    coef_we = 1'b0;
    pull(1'b0, 5);
    push(0, 1, -4, 1'b0);
    pull(1'b0, 6);
    write_coef(0, 0);
    push(0, 1, 4, 1'b0);
    pull(1'b0, 6);

    // Saturation
    do_reset();
    write_coef(0, 127);
    write_coef(1, 127);
    write_coef(2, 127);
    write_coef(3, -127);
    write_coef(4, 0);
    push(2, 127, 16129, 1'b0);
    pull(1'b0, 6);
    push(2, 127, 32767, 1'b1);
    pull(1'b0, 6);
    push(3, -127, -16129, 1'b0);
    pull(1'b0, 6);
    push(3, -127, -32768, 1'b1);
    pull(1'b0, 6);

    // Reset while in MAC discards the sample and clears state
    do_reset();
    push(0, 1, 4, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    any_v = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) any_v = 1'b1;
    end
    check("no_out_after_rst", any_v, 0);
    check("in_ready_after_rst", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      push(0, (i == 0) ? 1 : 0, imp_y[i], 1'b0);
      pull(1'b0, 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_mc.md
# iir_mc

Multi-channel, time-multiplexed second-order IIR filter (direct form I biquad) with runtime-loadable coefficients, valid/ready handshakes, output saturation and a single shared multiply-accumulate unit. It is the parametrised successor of the team's fixed-coefficient single-channel IIR. It sits between the sample source and downstream processing, and serves up to CHANNELS independent streams that share one coefficient set.

## Interface
- DATA_W, 8: signed input sample width
- OUT_W, 16: signed output and feedback-state width
- COEF_W, 8: signed coefficient width
- FRAC, 0: fractional bits of the coefficients; the accumulator is arithmetically shifted right by FRAC before saturation
- CHANNELS, 4: number of independent channel states, ≥1
- B0, 4 / B1, -4 / B2, 4 / A1, 1 / A2, 0: coefficient reset values
- CH_W (local): max(1, $clog2(CHANNELS)); ACC_W (local): OUT_W+COEF_W+3
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_ch  in  CH_W  channel index of the input sample
- in_data  in  DATA_W  signed input sample x[n]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_ch  out  CH_W  channel index of the result
- out_data  out  OUT_W  signed result y[n]
- out_sat  out  1  result was clipped
- coef_we  in  1  coefficient write strobe
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- coef_data  in  COEF_W  signed coefficient value

## Operation
- y[n] = sat((b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]) >>> FRAC). The shift is arithmetic and truncates toward −∞. sat clips to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Per-channel state: x1, x2 (DATA_W) and y1, y2 (OUT_W). State is updated only when a result is produced, and uses the saturated y.
- FSM states are IDLE, MAC, RES and OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and in_ch, clear acc, tap=0, go to MAC.
- MAC: one product per cycle, added to the signed ACC_W accumulator. Taps in order: b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2. After tap 4, go to RES.
- RES: compute y and out_sat, register out_data/out_ch/out_sat, update the state of in_ch (x2←x1, x1←x, y2←y1, y1←y), go to OUT.
- OUT: out_valid=1 with out_data, out_ch and out_sat stable. On out_ready, go to IDLE.
- Out-of-range channel (in_ch ≥ CHANNELS): the sample is accepted and all taps read zero state. The result is b0·x processed normally, and no state is written.
- Coefficient writes take effect only when the FSM is in IDLE; in any other state they are dropped. A write on the same edge as an input handshake applies to that sample.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, out_ch=0, out_sat=0. All channel states are 0 and acc is 0. Coefficients take B0..A2.
- Reset asserted in any state returns the FSM to IDLE on that edge. Any in-flight sample is discarded and no output is produced for it.
- Latency: a handshake at edge E0 gives MAC at E1..E5 and RES at E6. out_valid is high from E6 onward.
- Minimum period is 8 cycles per sample: output transfer at E7, in_ready high after E7, next accept at E8.
- in_ready=0 in MAC, RES and OUT. A sample presented then is held by the source; it is never lost.
- Under out_ready=0, out_valid and all out_* signals hold indefinitely.

## Test plan
- Impulse, default coefficients, ch0: inputs 1,0,0,0,0 → out_data 4, −8, 12, −12, 12; out_sat=0; each result 6 cycles after its accept.
- Channel isolation: alternate ch0 impulse-train samples with ch1 inputs of 0 → ch1 results all 0, and the ch0 sequence is identical to the previous scenario.
- Saturation: write b0=b1=b2=127, a1=−127, a2=0; feed 127 on ch2 twice → first result 16129 with sat=0, second result 32767 with sat=1. Negated input gives −32768 with sat=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → out_* stable and in_ready=0. Raise out_ready → transfer on one edge, then in_ready=1.
- Coefficient write while in MAC (b0←0) → ignored; the current and next sample use the old b0. The same write in IDLE → the next result reflects b0=0.
- Reset in MAC → no out_valid. An impulse after reset reproduces 4, −8, 12, confirming the state was cleared.
